// File: rtl/dt_pkg.sv
// Shared types and constants for the full-bridge dead-time gate driver.
// Holds the per-leg state encoding, command encodings and counter sizing.
package dt_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        LOW   = 3'd1,
        DT_UP = 3'd2,
        HIGH  = 3'd3,
        DT_DN = 3'd4,
        FAULT = 3'd5
    } leg_state_t;

    localparam logic [1:0] CMD_ZERO = 2'b00;
    localparam logic [1:0] CMD_POS  = 2'b10;
    localparam logic [1:0] CMD_NEG  = 2'b01;
    localparam logic [1:0] CMD_ILL  = 2'b11;

    // Width able to hold max(dead_cycles, min_on) inclusive.
    function automatic int cnt_width(input int dead_cycles, input int min_on);
        int m;
        int w;
        m = (dead_cycles > min_on) ? dead_cycles : min_on;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(m + 1)) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/half_bridge_leg.sv
// One half-bridge leg: break-before-make sequencing, minimum on-time dwell
// and an all-off fault state. Gate outputs are registered.
module half_bridge_leg
    import dt_pkg::*;
#(
    parameter int DEAD_CYCLES = 4,
    parameter int MIN_ON      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic fault,
    input  logic target,
    output logic hs,
    output logic ls
);

    localparam int               CNT_W   = cnt_width(DEAD_CYCLES, MIN_ON);
    localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] ON_SAT  = CNT_W'(MIN_ON);

    leg_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hs;
    logic             r_ls;

    logic             w_dt_done;
    logic             w_dwell_ok;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_sat;

    // The counter is cleared on entry to every state, so the same register
    // times the dead interval and the gate dwell. Dwell is met on the edge
    // MIN_ON periods after the gate asserted.
    assign w_dt_done  = (r_cnt >= DT_LAST);
    assign w_dwell_ok = (r_cnt >= ON_LAST);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_cnt_sat  = (r_cnt >= ON_SAT) ? r_cnt : w_cnt_inc;

    // Leg state machine with gate outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= CNT_W'(0);
            r_hs    <= 1'b0;
            r_ls    <= 1'b0;
        end else if (fault) begin
            r_state <= FAULT;
            r_cnt   <= CNT_W'(0);
            r_hs    <= 1'b0;
            r_ls    <= 1'b0;
        end else begin
            case (r_state)
                INIT, DT_DN: begin
                    r_hs <= 1'b0;
                    if (w_dt_done) begin
                        r_state <= LOW;
                        r_cnt   <= CNT_W'(0);
                        r_ls    <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_ls    <= 1'b0;
                    end
                end
                DT_UP: begin
                    r_ls <= 1'b0;
                    if (w_dt_done) begin
                        r_state <= HIGH;
                        r_cnt   <= CNT_W'(0);
                        r_hs    <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_hs    <= 1'b0;
                    end
                end
                LOW: begin
                    r_hs <= 1'b0;
                    if (target && w_dwell_ok) begin
                        r_state <= DT_UP;
                        r_cnt   <= CNT_W'(0);
                        r_ls    <= 1'b0;
                    end else begin
                        r_cnt   <= w_cnt_sat;
                        r_ls    <= 1'b1;
                    end
                end
                HIGH: begin
                    r_ls <= 1'b0;
                    if (!target && w_dwell_ok) begin
                        r_state <= DT_DN;
                        r_cnt   <= CNT_W'(0);
                        r_hs    <= 1'b0;
                    end else begin
                        r_cnt   <= w_cnt_sat;
                        r_hs    <= 1'b1;
                    end
                end
                FAULT: begin
                    r_state <= INIT;
                    r_cnt   <= CNT_W'(0);
                    r_hs    <= 1'b0;
                    r_ls    <= 1'b0;
                end
                default: begin
                    r_state <= INIT;
                    r_cnt   <= CNT_W'(0);
                    r_hs    <= 1'b0;
                    r_ls    <= 1'b0;
                end
            endcase
        end
    end

    assign hs = r_hs;
    assign ls = r_ls;

endmodule

// File: rtl/bridge_deadtime_driver.sv
// Full-bridge class-D gate driver: decodes the 1.5-bit command into per-leg
// targets, flags illegal commands and runs two independent leg sequencers.
module bridge_deadtime_driver
    import dt_pkg::*;
#(
    parameter int DEAD_CYCLES = 4,
    parameter int MIN_ON      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic fault,
    input  logic in_p,
    input  logic in_n,
    output logic hs_p,
    output logic ls_p,
    output logic hs_n,
    output logic ls_n,
    output logic illegal_err
);

    logic w_tgt_p;
    logic w_tgt_n;
    logic w_ill;
    logic r_illegal_err;

    // Command decode; the illegal code drives both legs low.
    always_comb begin
        w_tgt_p = 1'b0;
        w_tgt_n = 1'b0;
        w_ill   = 1'b0;
        case ({in_p, in_n})
            CMD_ZERO: begin
                w_tgt_p = 1'b0;
                w_tgt_n = 1'b0;
            end
            CMD_POS:  w_tgt_p = 1'b1;
            CMD_NEG:  w_tgt_n = 1'b1;
            CMD_ILL:  w_ill   = 1'b1;
            default: begin
                w_tgt_p = 1'b0;
                w_tgt_n = 1'b0;
                w_ill   = 1'b0;
            end
        endcase
    end

    // Sticky illegal-command flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_err <= 1'b0;
        end else if (w_ill) begin
            r_illegal_err <= 1'b1;
        end else begin
            r_illegal_err <= r_illegal_err;
        end
    end

    assign illegal_err = r_illegal_err;

    half_bridge_leg #(
        .DEAD_CYCLES(DEAD_CYCLES),
        .MIN_ON     (MIN_ON)
    ) u_leg_p (
        .clk   (clk),
        .rst   (rst),
        .fault (fault),
        .target(w_tgt_p),
        .hs    (hs_p),
        .ls    (ls_p)
    );

    half_bridge_leg #(
        .DEAD_CYCLES(DEAD_CYCLES),
        .MIN_ON     (MIN_ON)
    ) u_leg_n (
        .clk   (clk),
        .rst   (rst),
        .fault (fault),
        .target(w_tgt_n),
        .hs    (hs_n),
        .ls    (ls_n)
    );

endmodule

// File: doc/bridge_deadtime_driver.md
Name: bridge_deadtime_driver

Overview:
- Consumes the registered 1.5-bit command pair (in_p/in_n, one-hot or 00) produced by the sigma-delta output latch.
- Drives the four gate signals of the full-bridge class-D power stage.
- Per leg, guarantees break-before-make dead time, a minimum gate on-time (caps switching rate) and a safe all-off state on reset or fault.

Parameters:
- DEAD_CYCLES, 4, clock periods with both gates of a switching leg off; legal range >= 1.
- MIN_ON, 8, minimum clock periods a gate stays on once asserted; legal range >= 1.
- CNT_W, derived localparam = clog2(max(DEAD_CYCLES, MIN_ON)+1), width of each leg's counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fault  input  1  synchronous, active-high power-stage fault; forces all gates off.
- in_p  input  1  positive command from the 1.5-bit latch.
- in_n  input  1  negative command from the 1.5-bit latch.
- hs_p  output  1  high-side gate, leg P.
- ls_p  output  1  low-side gate, leg P.
- hs_n  output  1  high-side gate, leg N.
- ls_n  output  1  low-side gate, leg N.
- illegal_err  output  1  sticky flag: in_p=in_n=1 was sampled.

Behaviour:
- Command mapping: leg P target = in_p & ~in_n; leg N target = in_n & ~in_p. Target 1 means high side on, 0 means low side on. The 11 input maps to 00 (both legs low) and sets illegal_err.
- illegal_err is cleared only by rst.
- All gate outputs come directly from flops; no combinational path from inputs to gates.
- While rst is high: all gates 0, illegal_err 0, both legs in INIT with counter 0.
- Leg FSM states, each leg independent:
  - INIT: all off; counts DEAD_CYCLES, then goes to LOW.
  - LOW: ls=1.
  - DT_UP: all off; counts DEAD_CYCLES, then goes to HIGH.
  - HIGH: hs=1.
  - DT_DN: all off; counts DEAD_CYCLES, then goes to LOW.
  - FAULT: all off.
- Dwell counter is cleared on entry to LOW or HIGH and saturates at MIN_ON.
  - If the gate asserts after edge m, the earliest edge that can deassert it is m+MIN_ON.
- Switching: LOW with target=1 and dwell satisfied, sampled at edge k:
  - ls=0 after edge k;
  - hs=1 after edge k+DEAD_CYCLES.
  - Both gates are off for exactly DEAD_CYCLES periods. HIGH->LOW is symmetric via DT_DN.
- A command change during DT_UP/DT_DN is ignored. The transition commits; the new target is evaluated in the destination state once dwell is satisfied.
- A command change before dwell is satisfied is held off. The current target is re-sampled every cycle, so a glitch that reverts within the dwell window causes no switch.
- After rst deasserts: INIT runs DEAD_CYCLES with all off, then LOW (ls=1). Commands are ignored during INIT.
- fault=1 sampled at any edge, in any state: all four gates 0 after that edge; both legs enter FAULT and stay while fault=1.
- When fault is sampled 0 in FAULT: go to INIT. Restart is the full dead interval, then LOW.
- fault has priority over all command transitions. rst has priority over everything, asynchronously.
- Invariants, every cycle: never hs_x & ls_x on the same leg. A gate never changes directly from hs to ls without DEAD_CYCLES all-off.
- 00 command: both low sides on, so the load is shorted (zero output). 10: P high, N low. 01: P low, N high.

Decomposition:
- Shared package dt_pkg holds:
  - leg_state_t enum (INIT, LOW, DT_UP, HIGH, DT_DN, FAULT);
  - the CNT_W derivation function;
  - named constants for the command encodings (CMD_ZERO=2'b00, CMD_POS=2'b10, CMD_NEG=2'b01, CMD_ILL=2'b11).
- Sub-module half_bridge_leg holds one FSM plus counter with inputs clk, rst, fault, target and outputs hs, ls. It is instantiated twice.
- The top level holds command decode and the illegal_err flop.

Test Plan:
- Reset release, DEAD_CYCLES=4, MIN_ON=8: all gates 0 through 4 edges after rst falls; then ls_p=ls_n=1, hs_*=0.
- in_p=1 held after init dwell satisfied, sampled at edge k: ls_p=0 after k, hs_p=1 after k+4; leg N unchanged (ls_n=1).
- in_p pulses high 1 cycle right after hs_p asserts: hs_p stays 1 for exactly 8 cycles, then DT_DN for 4 cycles, then ls_p=1. A 1-cycle command glitch in LOW with dwell unsatisfied causes no gate change.
- in_p=in_n=1 for 1 cycle while both legs LOW: gates unchanged; illegal_err=1 and stays 1 until rst.
- fault raised while hs_p=1: all gates 0 the next edge. fault held 10 cycles then dropped: 4 all-off cycles after release, then ls_p=ls_n=1.
- Random legal/illegal commands, fault and async rst mid-DT_UP for 10k cycles: assertion checks never hs_x&ls_x, dead gap >= DEAD_CYCLES, on-time >= MIN_ON; all outputs 0 immediately on rst assertion.
